data_ram_responder: RTL and testbench

Responder side of the data-memory port driven by the memory-access pipeline stage. It accepts a word address, a 4-bit byte write enable and write data, and returns read data one clock later from a synchronous, byte-writable word array. After reset, an internal sequencer zero-fills the array before access is granted. A second read-only debug port lets the board display read memory while the CPU runs.

---
 rtl/data_ram_responder_pkg.sv | 21 ++
 rtl/data_ram_responder_bram.sv | 38 +++
 rtl/data_ram_responder.sv | 113 +++++++++++
 tb/tb_data_ram_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_e    : sequencer states (CLEAR = zero-fill in progress, READY = serving)
//   DM_LANES/LANE_W/WORD_W : byte-lane geometry of a memory word
//   addr_in_range : true when a byte address falls inside a 2^aw-word array
package data_ram_responder_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

  localparam int DM_LANES = 4;
  localparam int LANE_W   = 8;
  localparam int WORD_W   = DM_LANES * LANE_W;

  // Everything above the word-index field must be zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 32'd2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_ram_responder_bram.sv
// Dual-port word array, storage only.
//   clk     : clock, all ports synchronous
//   a_addr  : port A word index
//   a_wen   : port A byte write enables, bit i covers a_wdata lane i
//   a_wdata : port A write data
//   a_rdata : port A registered read data, read-first (old word on a same-cycle write)
//   b_addr  : port B word index (read only)
//   b_rdata : port B registered read data
module dm_bram_2p
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DM_LANES-1:0]   a_wen,
  input  logic [WORD_W-1:0]     a_wdata,
  output logic [WORD_W-1:0]     a_rdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WORD_W-1:0]     b_rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    a_rdata <= mem[a_addr];
    for (int i = 0; i < DM_LANES; i++) begin
      if (a_wen[i]) begin
        mem[a_addr][i*LANE_W +: LANE_W] <= a_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder for the MEM pipeline stage.
//   clk, reset  : clock and synchronous active-high reset
//   dm_addr     : CPU byte address (bits [1:0] ignored)
//   dm_wen      : byte write enables
//   dm_wdata    : lane-aligned write data
//   dm_rdata    : read data, one cycle after the address
//   dm_ready    : high once the post-reset zero-fill has finished
//   addr_err    : one-cycle flag, previous access was out of range
//   test_addr   : debug byte address
//   test_data   : debug read data, one cycle after test_addr
//
// state | meaning
// CLEAR | zero-filling the array one word per cycle, CPU locked out
// READY | serving CPU accesses until the next reset
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        addr_err,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((1 << ADDR_WIDTH) - 1);

  dm_state_e             state, state_nxt;
  logic [CNT_W-1:0]      fill_cnt, fill_cnt_nxt;
  logic                  dm_in_range, test_in_range;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_wen;
  logic [31:0]           ram_wdata, ram_rdata, dbg_rdata;
  logic                  rd_valid, rd_valid_nxt, addr_err_nxt, test_valid;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{dm_addr[1:0], test_addr[1:0]};

  assign dm_in_range   = addr_in_range(dm_addr, ADDR_WIDTH);
  assign test_in_range = addr_in_range(test_addr, ADDR_WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT_CLEAR ? CLEAR : READY;
      fill_cnt   <= '0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
      test_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fill_cnt   <= fill_cnt_nxt;
      rd_valid   <= rd_valid_nxt;
      addr_err   <= addr_err_nxt;
      test_valid <= test_in_range;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    ram_addr     = dm_addr[ADDR_WIDTH+1:2];
    ram_wen      = '0;
    ram_wdata    = dm_wdata;
    rd_valid_nxt = 1'b0;
    addr_err_nxt = 1'b0;
    case (state)
      CLEAR: begin
        // Port A is owned by the fill sequencer here; CPU writes never reach the array.
        ram_addr     = fill_cnt[ADDR_WIDTH-1:0];
        ram_wen      = '1;
        ram_wdata    = '0;
        fill_cnt_nxt = fill_cnt + 1'b1;
        if (fill_cnt == LAST_WORD) state_nxt = READY;
      end
      READY: begin
        if (dm_in_range) begin
          ram_wen      = dm_wen;
          rd_valid_nxt = 1'b1;
        end else begin
          addr_err_nxt = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
    // A reset cycle must not disturb the array, so contents survive reset in READY.
    if (reset) ram_wen = '0;
  end

  dm_bram_2p #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
    .clk     (clk),
    .a_addr  (ram_addr),
    .a_wen   (ram_wen),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_addr  (test_addr[ADDR_WIDTH+1:2]),
    .b_rdata (dbg_rdata)
  );

  // The RAM output registers carry no reset, so registered qualifiers zero them
  // during reset, fill and out-of-range accesses without adding latency.
  assign dm_rdata  = rd_valid ? ram_rdata : '0;
  assign test_data = test_valid ? dbg_rdata : '0;
  assign dm_ready  = (state == READY);

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, test_addr, test_data;
  logic [3:0]  dm_wen;
  logic        dm_ready, addr_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(4), .INIT_CLEAR(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .addr_err  (addr_err),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU access on the next edge and queue the response it should produce.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    dm_addr  = a;
    dm_wen   = w;
    dm_wdata = d;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    exp_q.push_back(e);
    tick();
    dm_wen = 4'b0000;
  endtask

  // Monitor: an item queued before an edge is answered right after that edge.
  initial begin
    int   due;
    exp_t e;
    forever begin
      @(posedge clk);
      due = exp_q.size();
      #2;
      if (due > 0) begin
        e = exp_q.pop_front();
        chk("rdata", dm_rdata, e.rdata);
        chk("addr_err", {31'b0, addr_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; dm_addr = '0; dm_wen = '0; dm_wdata = '0; test_addr = '0;
    #1;
    tick(); tick();
    chk("rst_ready", {31'b0, dm_ready}, 32'd0);
    chk("rst_rdata", dm_rdata, 32'd0);
    chk("rst_err",   {31'b0, addr_err}, 32'd0);
    chk("rst_test",  test_data, 32'd0);

    // First fill: ready after exactly 16 edges
    reset = 1'b0;
    n = 0;
    while (!dm_ready && n < 100) begin tick(); n++; end
    chk("fill1_cycles", n, 32'd16);

    for (int k = 0; k < 16; k++) access(32'(k * 4), 4'b0000, 32'h0, 32'h0, 1'b0);

    // Byte-enable writes and read-first behaviour at 0x8
    access(32'h8, 4'b1111, 32'h11223344, 32'h00000000, 1'b0);
    access(32'h8, 4'b0000, 32'h0,        32'h11223344, 1'b0);
    access(32'h8, 4'b0010, 32'h0000AB00, 32'h11223344, 1'b0);
    access(32'h8, 4'b0000, 32'h0,        32'h1122AB44, 1'b0);
    access(32'h8, 4'b1000, 32'hCD000000, 32'h1122AB44, 1'b0);
    access(32'h8, 4'b0000, 32'h0,        32'hCD22AB44, 1'b0);
    access(32'h8, 4'b1111, 32'hFFFFFFFF, 32'hCD22AB44, 1'b0);
    access(32'h8, 4'b0000, 32'h0,        32'hFFFFFFFF, 1'b0);

    // Out of range: data forced to 0, error pulses once, aliased word 0 untouched
    access(32'h0,   4'b1111, 32'h5A5A5A5A, 32'h0,        1'b0);
    access(32'h400, 4'b1111, 32'h12345678, 32'h0,        1'b1);
    access(32'h0,   4'b0000, 32'h0,        32'h5A5A5A5A, 1'b0);
    access(32'h40,  4'b0000, 32'h0,        32'h0,        1'b1);
    access(32'h0,   4'b0000, 32'h0,        32'h5A5A5A5A, 1'b0);

    // Patterns everywhere so the refill is observable
    for (int k = 0; k < 16; k++)
      access(32'(k * 4), 4'b1111, 32'hA5000000 | 32'(k),
             (k == 0) ? 32'h5A5A5A5A : (k == 2) ? 32'hFFFFFFFF : 32'h0, 1'b0);
    access(32'h14, 4'b0000, 32'h0, 32'hA5000005, 1'b0);
    access(32'h3C, 4'b0000, 32'h0, 32'hA500000F, 1'b0);
    tick();

    // Reset from READY: refill zeroes words in order, debug port tracks it
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_ready", {31'b0, dm_ready}, 32'd0);
    n = 0;
    while (!dm_ready && n < 100) begin
      test_addr = (n == 0) ? 32'h14 : 32'((n - 1) * 4);
      tick(); n++;
      if (n == 1) chk("sweep_unfilled", test_data, 32'hA5000005);
      else        chk("sweep_zero", test_data, 32'h0);
    end
    chk("fill2_cycles", n, 32'd16);
    test_addr = '0;
    access(32'h14, 4'b0000, 32'h0, 32'h0, 1'b0);

    // Reset mid-fill at counter 5, then a CPU write during the restarted fill
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (!dm_ready && n < 100) begin
      if (n == 12) begin dm_addr = 32'h8; dm_wen = 4'b1111; dm_wdata = 32'hDEADBEEF; end
      else dm_wen = 4'b0000;
      tick(); n++;
    end
    dm_wen = 4'b0000;
    chk("fill3_cycles", n, 32'd16);
    access(32'h8,  4'b0000, 32'h0, 32'h0, 1'b0);
    access(32'h3C, 4'b0000, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
